// File: rtl/md_unit_pkg.sv
// md_unit_pkg: md operation encodings and the combinational multiply/divide datapath
package md_unit_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  // A zero divisor and the INT_MIN/-1 overflow both divide by 1 instead: the first
  // keeps the arithmetic defined (its result is dropped), the second yields exactly
  // LO=0x80000000, HI=0. Signed mult sign-extends, since a 64-bit product mod 2^64
  // is then the signed product.
  function automatic md_res_t md_compute(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    md_res_t     r;
    logic        sx;
    logic [31:0] d;
    logic [31:0] qs;
    logic [31:0] rs;
    logic [63:0] prod;
    sx   = op == MD_MULT;
    d    = (b == 32'd0 || (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'd1 : b;
    prod = {{32{sx & a[31]}}, a} * {{32{sx & b[31]}}, b};
    qs   = $signed(a) / $signed(d);
    rs   = $signed(a) % $signed(d);
    r.valid = !((op == MD_DIV || op == MD_DIVU) && b == 32'd0);
    {r.hi, r.lo} = (op == MD_DIV) ? {rs, qs} : (op == MD_DIVU) ? {a % d, a / d} : prod;
    return r;
  endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO and fixed-latency busy emulation
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MD_OP_W-1:0] mdOp,
  input  logic [31:0]        srcA,
  input  logic [31:0]        srcB,
  output logic               start,
  output logic               busy,
  output logic               mdStall,
  output logic [31:0]        mdOut
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_op_e      op;
  md_res_t     res;
  logic        is_div;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_valid_q, pend_valid_d, busy_q, busy_d;
  logic [CW-1:0] count_q, count_d;

  assign op      = md_op_e'(mdOp);
  assign res     = md_compute(op, srcA, srcB);
  assign is_div  = op == MD_DIV || op == MD_DIVU;
  assign start   = op == MD_MULT || op == MD_MULTU || is_div;
  assign busy    = busy_q;
  assign mdStall = start | busy_q;
  assign mdOut   = (op == MD_MFHI) ? hi_q : (op == MD_MFLO) ? lo_q : 32'd0;

  // Next state: retire when the countdown expires, else accept a start or mthi/mtlo while idle
  always_comb begin
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    count_d      = count_q;
    busy_d       = busy_q;
    if (busy_q) begin
      if (count_q == '0) begin
        busy_d = 1'b0;
        hi_d   = pend_valid_q ? pend_hi_q : hi_q;
        lo_d   = pend_valid_q ? pend_lo_q : lo_q;
      end else begin
        count_d = count_q - CW'(1);
      end
    end else if (start) begin
      pend_hi_d    = res.hi;
      pend_lo_d    = res.lo;
      pend_valid_d = res.valid;
      count_d      = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      busy_d       = 1'b1;
    end else begin
      hi_d = (op == MD_MTHI) ? srcA : hi_q;
      lo_d = (op == MD_MTLO) ? srcA : lo_q;
    end
  end

  // Architectural and in-flight state; reset aborts any pending operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q         <= '0;
      lo_q         <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mdOp = 4'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        start, busy, mdStall;
  logic [31:0] mdOut;

  always #5 clk = ~clk;

  md_unit dut (
    .clk(clk), .rst_n(rst_n), .mdOp(mdOp), .srcA(srcA), .srcB(srcB),
    .start(start), .busy(busy), .mdStall(mdStall), .mdOut(mdOut)
  );

  typedef struct {
    string       name;
    logic        st;
    logic        bz;
    logic [31:0] out;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // One cycle of stimulus; its expected response goes to the scoreboard
  task automatic cyc(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic bz, input logic [31:0] out, input string name, input logic rn = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    mdOp  = op;
    srcA  = a;
    srcB  = b;
    e.name = name;
    e.st   = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    e.bz   = bz;
    e.out  = out;
    q.push_back(e);
  endtask

  task automatic run(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input int n, input string name);
    cyc(op, a, b, 1'b0, 32'd0, name);
    repeat (n) cyc(MD_NONE, 32'd0, 32'd0, 1'b1, 32'd0, name);
  endtask

  // Monitor: compares the DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (start !== e.st || busy !== e.bz || mdStall !== (e.st | e.bz) || mdOut !== e.out) begin
        failures++;
        $display("FAIL %s: got start=%b busy=%b stall=%b out=%h, want start=%b busy=%b stall=%b out=%h",
                 e.name, start, busy, mdStall, mdOut, e.st, e.bz, e.st | e.bz, e.out);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'd0, "rst_hi");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'd0, "rst_lo");
    cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 32'd0, "idle");
    run(MD_MULT, 32'hFFFF_FFFF, 32'd2, 5, "mult");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, "mult_hi");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFE, "mult_lo");
    run(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, "multu");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h0000_0001, "multu_hi");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFE, "multu_lo");
    run(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, "div");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFD, "div_lo");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, "div_hi");
    run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h8000_0000, "ovf_lo");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h0000_0000, "ovf_hi");
    run(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10, "divu");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h7FFF_FFFC, "divu_lo");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h0000_0001, "divu_hi");
    cyc(MD_MTLO, 32'h1234_5678, 32'd0, 1'b0, 32'd0, "mtlo");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h1234_5678, "mtlo_lo");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h0000_0001, "mtlo_hi");
    cyc(MD_MTHI, 32'hAABB_CCDD, 32'd0, 1'b0, 32'd0, "mthi");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'hAABB_CCDD, "mthi_hi");
    run(MD_DIV, 32'd5, 32'd0, 10, "div0");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'hAABB_CCDD, "div0_hi");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h1234_5678, "div0_lo");
    run(MD_DIV, 32'd100, 32'd7, 3, "div_abort");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'd0, "rst_mid", 1'b0);
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'd0, "rst_after");
    run(MD_MULT, 32'd3, 32'd4, 5, "mult_post");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h0000_000C, "post_lo");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h0000_0000, "post_hi");
    cyc(MD_MULT, 32'd7, 32'd6, 1'b0, 32'd0, "hold0");
    repeat (5) cyc(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0, "hold_busy");
    cyc(MD_MULT, 32'd9, 32'd9, 1'b0, 32'd0, "hold6");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b1, 32'h0000_002A, "stale_lo");
    repeat (4) cyc(MD_NONE, 32'd0, 32'd0, 1'b1, 32'd0, "hold_tail");
    cyc(MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h0000_0051, "hold_lo");
    cyc(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h0000_0000, "hold_hi");
    cyc(MD_NONE, 32'd0, 32'd0, 1'b0, 32'd0, "end");
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
